// File: rtl/fifo_pkg.sv
// Shared constants for the byte FIFO family: read-mode selectors and default sizing.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Default geometry and threshold levels.
  localparam int DEF_B        = 8;
  localparam int DEF_W        = 4;
  localparam int DEF_AF_LEVEL = 2**DEF_W - 2;
  localparam int DEF_AE_LEVEL = 1;

endpackage

// File: rtl/fifo_ram.sv
// Storage array for fifo_stat: one synchronous write port, one asynchronous-address read port.
module fifo_ram #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  // Write port: store the word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  // Read port is combinational on the address; the owner registers the data.
  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_stat.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module fifo_stat
  import fifo_pkg::*;
#(
  parameter int B        = DEF_B,
  parameter int W        = DEF_W,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);
  localparam logic [W:0] AF_L  = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_L  = (W+1)'(AE_LEVEL);

  logic [W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [W:0]   count_reg, count_next;
  logic         empty_reg, full_reg;
  logic         almost_empty_reg, almost_full_reg;
  logic         overflow_reg, overflow_next;
  logic         underflow_reg, underflow_next;
  logic [B-1:0] r_data_reg, r_data_next;

  logic         acc_wr, acc_rd;
  logic         bypass;
  logic [W-1:0] ram_r_addr;
  logic [B-1:0] ram_r_data;

  fifo_ram #(
    .B(B),
    .W(W)
  ) u_ram (
    .clk    (clk),
    .we     (acc_wr),
    .w_addr (wr_ptr_reg),
    .w_data (w_data),
    .r_addr (ram_r_addr),
    .r_data (ram_r_data)
  );

  // Request acceptance, pointer/count update and sticky error next-state.
  always_comb begin
    // A write into a full FIFO is still taken when a read frees a slot in the same cycle.
    acc_wr      = wr & (~full_reg | rd);
    acc_rd      = rd & ~empty_reg;
    wr_ptr_next = wr_ptr_reg + W'(acc_wr);
    rd_ptr_next = rd_ptr_reg + W'(acc_rd);
    count_next  = count_reg + (W+1)'(acc_wr) - (W+1)'(acc_rd);
    // The incoming word becomes the head when nothing else remains after this cycle's read.
    bypass      = acc_wr & (count_reg == (W+1)'(acc_rd));
    // Set beats clear so an error in the clearing cycle is never lost.
    overflow_next  = (wr & full_reg & ~rd) | (overflow_reg & ~clr_err);
    underflow_next = (rd & empty_reg) | (underflow_reg & ~clr_err);
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Look-ahead read: keep r_data equal to the head word whenever the FIFO is not empty.
      always_comb begin
        ram_r_addr  = rd_ptr_next;
        r_data_next = r_data_reg;
        if ((count_next != '0) && (acc_rd || empty_reg)) begin
          r_data_next = bypass ? w_data : ram_r_data;
        end
      end
    end else begin : g_std
      // Registered read: load the head word only on an accepted read, hold otherwise.
      always_comb begin
        ram_r_addr  = rd_ptr_reg;
        r_data_next = r_data_reg;
        if (acc_rd) begin
          r_data_next = ram_r_data;
        end
      end
    end
  endgenerate

  // State register: pointers, count, registered flags, errors and read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
      r_data_reg       <= '0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == DEPTH);
      almost_empty_reg <= (count_next <= AE_L);
      almost_full_reg  <= (count_next >= AF_L);
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
      r_data_reg       <= r_data_next;
    end
  end

  assign r_data       = r_data_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_empty = almost_empty_reg;
  assign almost_full  = almost_full_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_stat.sv
// Directed and randomised checks of fifo_stat in standard and FWFT modes (B=8, W=2, AF=3, AE=1).
module tb_fifo_stat;

  localparam int B = 8;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr;
  logic         rd;
  logic         clr_err;
  logic [B-1:0] w_data;

  logic [B-1:0] s_rdata, f_rdata;
  logic         s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic         f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [W:0]   s_count, f_count;

  // Packed status: count[16:14] empty full ae af ovf unf rdata[7:0]
  logic [16:0]  s_stat, f_stat;
  assign s_stat = {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf, s_rdata};
  assign f_stat = {f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_rdata};

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_stat #(.B(B), .W(W), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_std (
    .clk(clk), .reset_n(reset_n), .wr(wr), .w_data(w_data), .rd(rd), .clr_err(clr_err),
    .r_data(s_rdata), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
    .almost_full(s_af), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_stat #(.B(B), .W(W), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .wr(wr), .w_data(w_data), .rd(rd), .clr_err(clr_err),
    .r_data(f_rdata), .empty(f_empty), .full(f_full), .almost_empty(f_ae),
    .almost_full(f_af), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = '0;
    step(); step();
    reset_n = 1'b1;
    n_vec++;
    if (s_stat !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL reset_std: got %h want %h", s_stat, {3'd0, 6'b101000, 8'h00});
    end
    n_vec++;
    if (f_stat !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL reset_fwft: got %h want %h", f_stat, {3'd0, 6'b101000, 8'h00});
    end
    $display("test_reset: done");
  endtask

  task automatic test_fill_overflow();
    logic [16:0] exp;
    for (int k = 1; k <= 4; k++) begin
      wr = 1'b1; w_data = 8'(8'h11 * k);
      step();
      exp = {3'(k), 1'b0, (k == 4), (k <= 1), (k >= 3), 1'b0, 1'b0, 8'h00};
      n_vec++;
      if (s_stat !== exp) begin
        n_bad++; $display("FAIL fill_%0d: got %h want %h", k, s_stat, exp);
      end
      n_vec++;
      if (f_rdata !== 8'h11) begin
        n_bad++; $display("FAIL fill_fwft_head_%0d: got %h want 11", k, f_rdata);
      end
    end
    w_data = 8'h55;
    step();
    n_vec++;
    if (s_stat !== {3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL write_when_full: got %h want %h", s_stat, {3'd4, 6'b010110, 8'h00});
    end
    wr = 1'b0; rd = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {3'(4 - k), (k == 4), 1'b0, ((4 - k) <= 1), ((4 - k) >= 3), 1'b1, 1'b0, 8'(8'h11 * k)};
      n_vec++;
      if (s_stat !== exp) begin
        n_bad++; $display("FAIL drain_%0d: got %h want %h", k, s_stat, exp);
      end
      n_vec++;
      if (f_rdata !== ((k < 4) ? 8'(8'h11 * (k + 1)) : 8'h44)) begin
        n_bad++; $display("FAIL drain_fwft_%0d: got %h", k, f_rdata);
      end
    end
    rd = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_vec++;
    if (s_stat !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44}) begin
      n_bad++; $display("FAIL clr_overflow: got %h want %h", s_stat, {3'd0, 6'b101000, 8'h44});
    end
    $display("test_fill_overflow: done");
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [4];
    exp_q = '{8'hA3, 8'hB0, 8'hB1, 8'hB2};
    wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w_data = 8'(8'hA0 + k);
      step();
    end
    rd = 1'b1;
    for (int j = 0; j < 3; j++) begin
      w_data = 8'(8'hB0 + j);
      step();
      n_vec++;
      if (s_stat !== {3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hA0 + j)}) begin
        n_bad++; $display("FAIL full_rw_%0d: got %h want rdata %h count 4 full", j, s_stat, 8'hA0 + j);
      end
      n_vec++;
      if (f_rdata !== 8'(8'hA1 + j)) begin
        n_bad++; $display("FAIL full_rw_fwft_%0d: got %h want %h", j, f_rdata, 8'hA1 + j);
      end
    end
    wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if ((s_rdata !== exp_q[k]) || (s_count !== 3'(3 - k))) begin
        n_bad++; $display("FAIL wrap_order_%0d: got %h/%0d want %h/%0d", k, s_rdata, s_count, exp_q[k], 3 - k);
      end
    end
    rd = 1'b0;
    n_vec++;
    if ((s_empty !== 1'b1) || (s_ovf !== 1'b0)) begin
      n_bad++; $display("FAIL full_rw_end: got empty %b ovf %b want 1 0", s_empty, s_ovf);
    end
    $display("test_full_rw: done");
  endtask

  task automatic test_empty_rw();
    wr = 1'b1; rd = 1'b1; w_data = 8'hA5;
    step();
    wr = 1'b0; rd = 1'b0;
    n_vec++;
    if (s_stat !== {3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2}) begin
      n_bad++; $display("FAIL empty_rw: got %h want %h", s_stat, {3'd1, 6'b001001, 8'hB2});
    end
    n_vec++;
    if ((f_rdata !== 8'hA5) || (f_empty !== 1'b0)) begin
      n_bad++; $display("FAIL empty_rw_fwft: got %h empty %b want a5 0", f_rdata, f_empty);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if ((s_rdata !== 8'hA5) || (s_count !== 3'd0) || (s_unf !== 1'b1)) begin
      n_bad++; $display("FAIL empty_rw_read: got %h cnt %0d unf %b want a5 0 1", s_rdata, s_count, s_unf);
    end
    clr_err = 1'b1;
    step();
    n_vec++;
    if (s_unf !== 1'b0) begin
      n_bad++; $display("FAIL clr_underflow: got %b want 0", s_unf);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if ((s_unf !== 1'b1) || (f_unf !== 1'b1)) begin
      n_bad++; $display("FAIL set_beats_clear: got %b/%b want 1/1", s_unf, f_unf);
    end
    step();
    clr_err = 1'b0;
    n_vec++;
    if (s_unf !== 1'b0) begin
      n_bad++; $display("FAIL clr_after_set: got %b want 0", s_unf);
    end
    $display("test_empty_rw: done");
  endtask

  task automatic test_fwft();
    wr = 1'b1; w_data = 8'h3C;
    step();
    wr = 1'b0;
    n_vec++;
    if ((f_empty !== 1'b0) || (f_rdata !== 8'h3C) || (f_count !== 3'd1)) begin
      n_bad++; $display("FAIL fwft_fall_through: got e%b %h c%0d want e0 3c c1", f_empty, f_rdata, f_count);
    end
    step();
    n_vec++;
    if ((f_empty !== 1'b0) || (f_rdata !== 8'h3C)) begin
      n_bad++; $display("FAIL fwft_hold: got e%b %h want e0 3c", f_empty, f_rdata);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if ((f_empty !== 1'b1) || (f_count !== 3'd0) || (f_rdata !== 8'h3C)) begin
      n_bad++; $display("FAIL fwft_pop_last: got e%b c%0d %h want e1 c0 3c", f_empty, f_count, f_rdata);
    end
    wr = 1'b1; w_data = 8'h01;
    step();
    rd = 1'b1; w_data = 8'h02;
    step();
    wr = 1'b0;
    n_vec++;
    if ((f_rdata !== 8'h02) || (f_count !== 3'd1) || (f_empty !== 1'b0)) begin
      n_bad++; $display("FAIL fwft_pop_push_one: got %h c%0d e%b want 02 c1 e0", f_rdata, f_count, f_empty);
    end
    step();
    rd = 1'b0;
    n_vec++;
    if ((f_empty !== 1'b1) || (s_rdata !== 8'h02)) begin
      n_bad++; $display("FAIL fwft_drain: got e%b std %h want e1 02", f_empty, s_rdata);
    end
    $display("test_fwft: done");
  endtask

  task automatic test_reset_mid();
    rd = 1'b1;
    step();
    rd = 1'b0; wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w_data = 8'(8'h71 + k);
      step();
    end
    wr = 1'b0;
    n_vec++;
    if ((s_count !== 3'd3) || (s_unf !== 1'b1) || (s_af !== 1'b1)) begin
      n_bad++; $display("FAIL pre_reset: got c%0d unf %b af %b want c3 1 1", s_count, s_unf, s_af);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_vec++;
    if (s_stat !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL mid_reset_std: got %h want %h", s_stat, {3'd0, 6'b101000, 8'h00});
    end
    n_vec++;
    if (f_stat !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL mid_reset_fwft: got %h want %h", f_stat, {3'd0, 6'b101000, 8'h00});
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if (s_stat !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL no_stale_read: got %h want %h", s_stat, {3'd0, 6'b101001, 8'h00});
    end
    wr = 1'b1; w_data = 8'h99;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if ((s_rdata !== 8'h99) || (s_count !== 3'd0)) begin
      n_bad++; $display("FAIL post_reset_rw: got %h c%0d want 99 c0", s_rdata, s_count);
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_random();
    logic [7:0]  q [$];
    logic [7:0]  e_s, e_f;
    logic        e_ovf, e_unf, fl, em;
    logic [16:0] exp_s, exp_f;
    int          sz;
    int          shown;
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    step();
    reset_n = 1'b1;
    e_s = '0; e_f = '0; e_ovf = 1'b0; e_unf = 1'b0; shown = 0;
    for (int c = 0; c < 10000; c++) begin
      wr      = 1'($urandom_range(0, 1));
      rd      = 1'($urandom_range(0, 1));
      clr_err = ($urandom_range(0, 15) == 0);
      w_data  = 8'($urandom);
      fl = (q.size() == 4);
      em = (q.size() == 0);
      e_ovf = (wr && fl && !rd) ? 1'b1 : (clr_err ? 1'b0 : e_ovf);
      e_unf = (rd && em) ? 1'b1 : (clr_err ? 1'b0 : e_unf);
      if (rd && !em) e_s = q.pop_front();
      if (wr && (!fl || rd)) q.push_back(w_data);
      if (q.size() > 0) e_f = q[0];
      sz = q.size();
      step();
      exp_s = {3'(sz), (sz == 0), (sz == 4), (sz <= 1), (sz >= 3), e_ovf, e_unf, e_s};
      exp_f = {3'(sz), (sz == 0), (sz == 4), (sz <= 1), (sz >= 3), e_ovf, e_unf, e_f};
      n_vec++;
      if (s_stat !== exp_s) begin
        n_bad++;
        if (shown < 10) $display("FAIL random_std cycle %0d: got %h want %h", c, s_stat, exp_s);
        shown++;
      end
      n_vec++;
      if (f_stat !== exp_f) begin
        n_bad++;
        if (shown < 10) $display("FAIL random_fwft cycle %0d: got %h want %h", c, f_stat, exp_f);
        shown++;
      end
    end
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    $display("test_random: 10000 cycles done");
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
